// File: rtl/gate_pkg.sv
// Shared definitions for the 2-input gate self-test checker: FSM states,
// vector count and the expected truth tables of the basic library gates.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 4;

  // Truth tables are indexed by {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_bist_checker.sv
// Self-test engine for a 2-input gate: steps {a,b} through all four vectors,
// samples y after a settle window and accumulates a per-vector fail mask.
module gate_bist_checker
  import gate_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_XNOR,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  localparam int              CW       = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES);
  localparam logic [1:0]      IDX_LAST = 2'(NUM_VECTORS - 1);

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_VECTORS-1:0] fail_q, fail_d;
  logic [2:0]             err_q, err_d;
  logic [1:0]             ab_q, ab_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    err_d   = err_q;
    ab_d    = 2'b00;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 2'd0;
          cnt_d   = '0;
          fail_d  = '0;
          err_d   = 3'd0;
          ab_d    = 2'd0;
        end
      end
      RUN: begin
        ab_d = idx_q;
        // Last cycle of the vector: y has settled, sample and compare.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (y != TRUTH_TABLE[idx_q]) begin
            fail_d[idx_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            ab_d    = 2'b00;
          end else begin
            idx_d = idx_q + 2'd1;
            ab_d  = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      fail_q  <= '0;
      err_q   <= 3'd0;
      ab_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      ab_q    <= ab_d;
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (fail_q == '0);
  assign fail_mask = fail_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: a table-driven gate model feeds y, and the
// expected results come from comparing the model gate against the table.
module tb_gate_bist_checker;
  import gate_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] start_s;
  logic [1:0] a_w, b_w, busy_w, done_w, pass_w, y_w;
  logic [3:0] fm0, fm1;
  logic [2:0] ec0, ec1;
  logic [3:0] gtt0, gtt1;

  int n_pass = 0;
  int n_total = 0;

  assign y_w[0] = gtt0[{a_w[0], b_w[0]}];
  assign y_w[1] = gtt1[{a_w[1], b_w[1]}];

  gate_bist_checker #(.TRUTH_TABLE(TT_XNOR), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start_s[0]), .y(y_w[0]),
    .a(a_w[0]), .b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .fail_mask(fm0), .err_count(ec0)
  );

  gate_bist_checker #(.TRUTH_TABLE(TT_XNOR), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[1]), .y(y_w[1]),
    .a(a_w[1]), .b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .fail_mask(fm1), .err_count(ec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int outs_of(input int d);
    if (d == 0) return {a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], fm0, ec0};
    return {a_w[1], b_w[1], busy_w[1], done_w[1], pass_w[1], fm1, ec1};
  endfunction

  // One complete run on checker d, with an optional stray start at cycle glitch.
  task automatic run(input int d, input logic [3:0] tt, input int glitch,
                     input logic [3:0] em, input logic [2:0] ee, input logic ep);
    int s;
    int k;
    int bad;
    logic [1:0] seq[$];
    s = (d == 0) ? 2 : 0;
    if (d == 0) gtt0 = tt; else gtt1 = tt;
    @(negedge clk);
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    k = 1;
    chk("start_accept", {busy_w[d], done_w[d], pass_w[d]}, 3'b100);
    while (!done_w[d] && k < 200) begin
      if (busy_w[d]) seq.push_back({a_w[d], b_w[d]});
      @(negedge clk);
      k++;
      if (glitch > 0) start_s[d] = (k == glitch);
    end
    start_s[d] = 1'b0;
    chk("latency", k - 1, 4 * (s + 1));
    chk("done", done_w[d], 1);
    chk("busy_off", busy_w[d], 0);
    chk("pass", pass_w[d], ep);
    chk("fail_mask", (d == 0) ? fm0 : fm1, em);
    chk("err_count", (d == 0) ? ec0 : ec1, ee);
    chk("ab_idle", {a_w[d], b_w[d]}, 0);
    chk("ab_len", seq.size(), 4 * (s + 1));
    bad = 0;
    for (int i = 0; i < seq.size(); i++)
      if (seq[i] != 2'(i / (s + 1))) bad++;
    chk("ab_seq", bad, 0);
  endtask

  typedef struct {
    int         d;
    logic [3:0] tt;
    int         glitch;
    logic [3:0] em;
    logic [2:0] ee;
    logic       ep;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [3:0] rtt;
    logic [3:0] rm;
    int rd;
    vt[0] = '{0, TT_XNOR, 0, 4'b0000, 3'd0, 1'b1};
    vt[1] = '{0, TT_AND,  0, 4'b0001, 3'd1, 1'b0};
    vt[2] = '{0, 4'b0000, 0, 4'b1001, 3'd2, 1'b0};
    vt[3] = '{0, TT_XNOR, 5, 4'b0000, 3'd0, 1'b1};
    vt[4] = '{0, TT_XOR,  5, 4'b1111, 3'd4, 1'b0};
    vt[5] = '{1, TT_XNOR, 0, 4'b0000, 3'd0, 1'b1};
    vt[6] = '{1, TT_NAND, 0, 4'b1110, 3'd3, 1'b0};
    vt[7] = '{1, 4'b1111, 0, 4'b0110, 3'd2, 1'b0};

    rst = 1'b1;
    start_s = 2'b00;
    gtt0 = TT_XNOR;
    gtt1 = TT_XNOR;
    repeat (2) @(negedge clk);
    chk("reset_outs0", outs_of(0), 0);
    chk("reset_outs1", outs_of(1), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run(vt[i].d, vt[i].tt, vt[i].glitch, vt[i].em, vt[i].ee, vt[i].ep);

    // Start issued from DONE on the single-cycle checker.
    run(1, TT_XNOR, 0, 4'b0000, 3'd0, 1'b1);
    run(1, TT_OR, 0, 4'b0111, 3'd3, 1'b0);

    // Asynchronous reset while vector {a,b}=10 is presented.
    gtt0 = TT_XNOR;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_ab", {a_w[0], b_w[0], busy_w[0]}, 3'b101);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", outs_of(0), 0);
    @(negedge clk);
    chk("rst_hold_outs", outs_of(0), 0);
    rst = 1'b0;
    run(0, TT_XNOR, 0, 4'b0000, 3'd0, 1'b1);

    // Random gates against the XNOR expectation.
    for (int i = 0; i < 10; i++) begin
      rtt = 4'($urandom);
      rd = int'($urandom_range(1, 0));
      rm = rtt ^ TT_XNOR;
      run(rd, rtt, 0, rm, 3'($countones(rm)), rm == 4'b0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
- Hardware self-test engine for a 2-input basic gate. It drives the gate's a/b inputs through all four combinations, samples y, and compares each sample against an expected truth table.
- Sits beside any 2-input gate in the library (xnor, and, or, ...) as the on-chip checking end of the gate interface.
- Reports a per-vector fail mask, an error count and a pass/done status.

Parameters:
- TRUTH_TABLE, 4'b1001, expected y for each vector; bit index = {a,b}. The default is XNOR.
- SETTLE_CYCLES, 2, extra cycles a vector is held before y is sampled; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a run
- y  input  1  output of the gate under test
- a  output  1  gate input a (registered)
- b  output  1  gate input b (registered)
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until the next accepted start or reset
- pass  output  1  high only when done=1 and fail_mask==0
- fail_mask  output  4  bit i set if vector {a,b}=i mismatched
- err_count  output  3  number of mismatching vectors, 0..4

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - state returns to IDLE immediately.
  - a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN; idx=0; settle counter=0; fail_mask and err_count cleared.
  - RUN: {a,b}=idx, registered, so the values are valid from the cycle after the state is entered or idx advances.
    - Each vector occupies exactly SETTLE_CYCLES+1 cycles.
    - On the last cycle's rising edge, y is sampled and compared to TRUTH_TABLE[idx]. On mismatch, fail_mask[idx] is set and err_count is incremented.
    - If idx<3: idx increments and the counter clears.
    - If idx==3: -> DONE.
  - DONE: done=1, busy=0. a/b return to 0. pass = (fail_mask==0). Results hold until start or rst.
    - start=1 -> RUN, with the same clearing as from IDLE. done and pass drop on that edge.
- busy=1 exactly while in RUN.
- Latency: the start acceptance edge to the done rising edge is 4*(SETTLE_CYCLES+1) cycles.
- start while busy is ignored; there is no restart, no queueing and no effect on results.
- SETTLE_CYCLES=0: one cycle per vector; y is sampled in the same cycle the vector is presented on a/b.
- The settle counter is sized $clog2(SETTLE_CYCLES+1), with a minimum of 1 bit. The counter wraps only via an explicit clear, never by overflow.
- err_count always equals the popcount of fail_mask. It cannot exceed 4 and never wraps.
- y is treated as an ordinary 2-state input. No synchronizer is included; the gate under test shares clk's domain.

Decomposition:
- Shared package gate_pkg:
  - state encoding typedef (IDLE/RUN/DONE).
  - NUM_VECTORS=4.
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_XNOR=4'b1001, TT_NAND=4'b0111, TT_NOR=4'b0001.
- Single module. No sub-module is warranted; the settle counter and vector index stay inline.

Test Plan:
- XNOR gate, defaults, start pulse -> a/b step through 00,01,10,11, each held 3 cycles; done rises 12 cycles after the start edge; fail_mask=0000, err_count=0, pass=1.
- AND gate wired to the checker, TRUTH_TABLE=TT_XNOR -> mismatch only at vector 00; fail_mask=0001, err_count=1, pass=0, done=1.
- y stuck at 0 with TT_XNOR -> fail_mask=1001, err_count=2, pass=0.
- start pulsed again while busy at cycle 5 of a run -> ignored; done still arrives 12 cycles after the first start and results are unchanged.
- rst asserted asynchronously mid-run (vector 10), then released, then start -> all outputs 0 immediately on rst; the fresh run completes with a correct XNOR pass.
- SETTLE_CYCLES=0 with TT_XNOR, then a second start issued in DONE -> 4-cycle run, pass=1; the second start drops done and pass and the next run completes again after 4 cycles.
